// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, W data bits MSB-first, optional even parity, stop bit,
// then a one-word valid/ready holding buffer. Optional parity state enabled by SFRX_PARITY_EN.
module serial_frame_rx #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W)
) (
    input  logic         ck,
    input  logic         rstN,
    input  logic         clr,
    input  logic         bitEn,
    input  logic         sIn,
    output logic [W-1:0] q,
    output logic         qValid,
    input  logic         qReady,
    output logic         busy,
    output logic         frameErr,
    output logic         overrun,
    output logic         parErr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_shreg;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_q;
    logic           r_q_valid;
    logic           r_busy;
    logic           r_frame_err;
    logic           r_overrun;
    logic           r_par_err;

    logic           w_start;
    logic           w_shift;
    logic           w_load;
    logic           w_ovr_set;
    logic           w_ferr;
    logic           w_perr;
    logic           w_par_bad;
    logic           w_free;
    logic           w_last;

    assign w_free = !r_q_valid || qReady;
    assign w_last = (r_cnt == CW'(W - 1));

`ifdef SFRX_PARITY_EN
    logic           r_pbit;
    // Even parity over data plus parity bit must come out 0.
    assign w_par_bad = ^{r_shreg, r_pbit};

    always_ff @(posedge ck or negedge rstN) begin
        if (!rstN)
            r_pbit <= 1'b0;
        else if (clr)
            r_pbit <= 1'b0;
        else if (bitEn && r_state == S_PARITY)
            r_pbit <= sIn;
    end
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge ck or negedge rstN) begin
        if (!rstN)
            r_state <= S_IDLE;
        else if (clr)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and per-strobe events; nothing moves without bitEn.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_ovr_set   = 1'b0;
        w_ferr      = 1'b0;
        w_perr      = 1'b0;
        if (bitEn) begin
            case (r_state)
                S_IDLE: begin
                    if (!sIn) begin
                        w_state_nxt = S_DATA;
                        w_start     = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift = 1'b1;
                    if (w_last) begin
`ifdef SFRX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
`ifdef SFRX_PARITY_EN
                S_PARITY: w_state_nxt = S_STOP;
`endif
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (!sIn) begin
                        w_ferr = 1'b1;
                        w_perr = w_par_bad;
                    end else if (w_par_bad) begin
                        w_perr = 1'b1;
                    end else if (w_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_ovr_set = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ck or negedge rstN) begin
        if (!rstN) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_par_err   <= 1'b0;
        end else if (clr) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_shreg <= '0;
                r_cnt   <= '0;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[W-2:0], sIn};
                // Counter saturates at W-1 on the last data strobe.
                if (!w_last)
                    r_cnt <= r_cnt + CW'(1);
            end
            if (w_load) begin
                r_q       <= r_shreg;
                r_q_valid <= 1'b1;
            end else if (r_q_valid && qReady) begin
                r_q_valid <= 1'b0;
            end
            if (w_ovr_set)
                r_overrun <= 1'b1;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_err <= w_ferr;
            r_par_err   <= w_perr;
        end
    end

    assign q        = r_q;
    assign qValid   = r_q_valid;
    assign busy     = r_busy;
    assign frameErr = r_frame_err;
    assign overrun  = r_overrun;
    assign parErr   = r_par_err;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (W=8); parity cases run when SFRX_PARITY_EN is defined.
module tb_serial_frame_rx;

    localparam int unsigned W = 8;

    localparam int K_LOAD = 0;
    localparam int K_OVR  = 1;
    localparam int K_FERR = 2;
    localparam int K_PERR = 3;

    logic         ck;
    logic         rstN;
    logic         clr;
    logic         bitEn;
    logic         sIn;
    logic [W-1:0] q;
    logic         qValid;
    logic         qReady;
    logic         busy;
    logic         frameErr;
    logic         overrun;
    logic         parErr;

    int n_checks;
    int n_errors;
    logic [W-1:0] sb[$];

    serial_frame_rx #(.W(W)) dut (
        .ck       (ck),
        .rstN     (rstN),
        .clr      (clr),
        .bitEn    (bitEn),
        .sIn      (sIn),
        .q        (q),
        .qValid   (qValid),
        .qReady   (qReady),
        .busy     (busy),
        .frameErr (frameErr),
        .overrun  (overrun),
        .parErr   (parErr)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumption side of the scoreboard: every accepted word must match the oldest expected one.
    always @(negedge ck) begin
        if (rstN && qValid && qReady) begin
            if (sb.size() == 0)
                chk("sb_unexpected_word", 32'(q), 32'hFFFF_FFFF);
            else
                chk("sb_q", 32'(q), 32'(sb.pop_front()));
        end
    end

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        sIn   = b;
        bitEn = 1'b1;
        @(posedge ck);
        #1;
        bitEn = 1'b0;
        sIn   = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic pbit,
                              input int kind, input logic exp_qv);
        strobe(1'b0);
        gap(3);
        for (int i = W - 1; i >= 0; i--) begin
            strobe(d[i]);
            gap(3);
        end
`ifdef SFRX_PARITY_EN
        strobe(pbit);
        gap(3);
`else
        if (pbit === 1'bx) $display("unused parity bit");
`endif
        if (kind == K_LOAD) sb.push_back(d);
        strobe(stop);
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("qvalid_after_stop", 32'(qValid), 32'(exp_qv));
        chk("frameerr_pulse", 32'(frameErr), 32'(kind == K_FERR));
`ifdef SFRX_PARITY_EN
        chk("parerr_pulse", 32'(parErr), 32'(kind == K_PERR));
`endif
        if (kind == K_OVR) chk("overrun_set", 32'(overrun), 32'd1);
        gap(1);
        chk("frameerr_one_cycle", 32'(frameErr), 32'd0);
        chk("parerr_one_cycle", 32'(parErr), 32'd0);
        gap(2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstN   = 1'b0;
        clr    = 1'b0;
        bitEn  = 1'b0;
        sIn    = 1'b1;
        qReady = 1'b1;
        gap(2);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_qvalid", 32'(qValid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({frameErr, overrun, parErr}), 32'd0);
        rstN = 1'b1;
        gap(2);

        // Idle-high line strobed every cycle must never leave IDLE.
        bitEn = 1'b1;
        sIn   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge ck);
            #1;
            chk("idle_busy", 32'(busy), 32'd0);
        end
        bitEn = 1'b0;

        // Asynchronous reset in the middle of a data phase.
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        chk("mid_data_busy", 32'(busy), 32'd1);
        rstN = 1'b0;
        @(posedge ck);
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_outs", 32'({q, qValid, frameErr, overrun, parErr}), 32'd0);
        rstN = 1'b1;
        gap(2);

        // Basic frame, consumer always ready.
        send_frame(8'hA5, 1'b1, ^8'hA5, K_LOAD, 1'b1);
        chk("a5_qvalid_dropped", 32'(qValid), 32'd0);

        // Backpressure: second word dropped and overrun latched.
        qReady = 1'b0;
        send_frame(8'h3C, 1'b1, ^8'h3C, K_LOAD, 1'b1);
        send_frame(8'h81, 1'b1, ^8'h81, K_OVR, 1'b1);
        chk("ovr_q_held", 32'(q), 32'h3C);
        chk("ovr_qvalid_held", 32'(qValid), 32'd1);
        qReady = 1'b1;
        gap(2);
        chk("ovr_qvalid_drained", 32'(qValid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        clr = 1'b1;
        gap(1);
        clr = 1'b0;
        chk("clr_overrun", 32'(overrun), 32'd0);
        chk("clr_q", 32'(q), 32'd0);

        // Framing error, then a clean frame.
        send_frame(8'hFF, 1'b0, ^8'hFF, K_FERR, 1'b0);
        send_frame(8'h12, 1'b1, ^8'h12, K_LOAD, 1'b1);

        // Clear after four data bits; partial bits must not leak into the next word.
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b1);
        clr = 1'b1;
        gap(1);
        clr = 1'b0;
        chk("clr_mid_busy", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b1, ^8'h5A, K_LOAD, 1'b1);

`ifdef SFRX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, K_LOAD, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, K_PERR, 1'b0);
`endif

        gap(4);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
